// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, reads one word per cycle from a
// combinational instruction memory and queues {pc, word} pairs for decode.
module instruction_fetch #(
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  output logic        imem_we,
  output logic [31:0] imem_din,
  input  logic [31:0] imem_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted
);

  localparam int          PTR_W      = $clog2(DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);
  localparam logic [31:0] RESET_PC_W = 32'(RESET_PC % MEM_SIZE);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        inst_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];

  logic               fire;
  logic               push;
  logic               pop;
  logic [31:0]        pc_inc;

  // Handshake: an entry transfers on any rising edge where inst_valid and
  // inst_ready are both high; inst/inst_pc hold steady while inst_ready is low.
  // fire looks only at the registered count, so a same-cycle pop never frees a slot.
  assign fire   = (state_q == S_FETCH) && enable && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
  assign push   = fire && (imem_out != 32'd0);
  assign pop    = inst_valid && inst_ready;
  assign pc_inc = (pc_q == MEM_SIZE_W - 32'd1) ? 32'd0 : pc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc % MEM_SIZE_W;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_inc;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (fire && (imem_out == 32'd0)) begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC_W;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_out;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q] : 32'd0;
  assign halted     = (state_q == S_HALT);

  assign imem_addr  = pc_q;
  assign imem_re    = fire;
  assign imem_we    = 1'b0;
  assign imem_din   = 32'd0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a random run, all
// checked against a transaction-level queue model of the fetch front end.
module tb_instruction_fetch;

  localparam int          DEPTH    = 2;
  localparam int          MEM_SIZE = 256;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic        imem_we;
  logic [31:0] imem_din;
  logic [31:0] imem_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  logic [31:0] imem [MEM_SIZE];
  assign imem_out = imem[imem_addr[7:0]];

  instruction_fetch #(
    .RESET_PC(0),
    .DEPTH(DEPTH),
    .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .imem_addr(imem_addr),
    .imem_re(imem_re),
    .imem_we(imem_we),
    .imem_din(imem_din),
    .imem_out(imem_out),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: PC, halt flag, and a queue of {pc, word} entries.
  logic [31:0] m_pc;
  logic        m_halt;
  logic [63:0] exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  logic [131:0] obs_vec;
  assign obs_vec = {inst_valid, inst_pc, inst, imem_re, imem_addr, halted, imem_we, imem_din};

  function automatic logic [131:0] exp_vec();
    logic        fire_now;
    logic [63:0] head;
    fire_now = !m_halt && enable && (exp_q.size() < DEPTH) && !redirect_valid;
    head     = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
    return {exp_q.size() != 0, head, fire_now, m_pc, m_halt, 1'b0, 32'd0};
  endfunction

  task automatic advance();
    logic        fire_now;
    logic [31:0] w;
    if (rst) begin
      m_pc   = RESET_PC;
      m_halt = 1'b0;
      exp_q.delete();
    end else if (redirect_valid) begin
      m_pc   = redirect_pc % 32'(MEM_SIZE);
      m_halt = 1'b0;
      exp_q.delete();
    end else begin
      fire_now = !m_halt && enable && (exp_q.size() < DEPTH);
      if (exp_q.size() != 0 && inst_ready) exp_q.delete(0);
      if (fire_now) begin
        w = imem[m_pc];
        if (w != 32'd0) begin
          exp_q.push_back({m_pc, w});
          m_pc = (m_pc + 32'd1) % 32'(MEM_SIZE);
        end else begin
          m_halt = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    advance();
    advance();
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== RESET_PC || inst !== 32'd0 || inst_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%b halted=%b addr=%0d inst=%h pc=%0d exp 0 0 %0d 0 0",
               inst_valid, halted, imem_addr, inst, inst_pc, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int first_cyc;
    first_cyc = -1;
    got_pc.delete(); got_inst.delete();
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL seq_cycle%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (inst_valid && first_cyc < 0) first_cyc = i;
      if (inst_valid && inst_ready) begin got_pc.push_back(inst_pc); got_inst.push_back(inst); end
      advance();
    end
    checks++;
    if (first_cyc !== 1) begin
      failures++;
      $display("FAIL seq_first_valid got cycle=%0d exp cycle=1", first_cyc);
    end
    checks++;
    if (got_pc.size() != 7) begin
      failures++;
      $display("FAIL seq_count got=%0d exp=7", got_pc.size());
    end
    for (int k = 0; k < got_pc.size(); k++) begin
      checks++;
      if (got_pc[k] !== 32'(k)) begin
        failures++;
        $display("FAIL seq_order idx=%0d got=%0d exp=%0d", k, got_pc[k], k);
      end
    end
    checks++;
    if (got_inst.size() == 0 || got_inst[0] !== 32'h00302083) begin
      failures++;
      $display("FAIL seq_word0 got=%h exp=00302083", (got_inst.size() != 0) ? got_inst[0] : 32'hx);
    end
  endtask

  task automatic test_halt();
    #1;
    checks++;
    if (halted !== 1'b1 || imem_re !== 1'b0 || imem_addr !== 32'd7 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_entry got halted=%b re=%b addr=%0d valid=%b exp 1 0 7 0", halted, imem_re, imem_addr, inst_valid);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL halt_hold%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      advance();
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    #1;
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL halt_redirect got=%h exp=%h", obs_vec, exp_vec());
    end
    advance();
    redirect_valid = 1'b0;
    got_pc.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL halt_resume%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (inst_valid && inst_ready) got_pc.push_back(inst_pc);
      advance();
    end
    checks++;
    if (halted !== 1'b0 || got_pc.size() != 3 || got_pc[0] !== 32'd0 || got_pc[2] !== 32'd2) begin
      failures++;
      $display("FAIL halt_resume_seq got halted=%b n=%0d exp halted=0 n=3 pcs 0,1,2", halted, got_pc.size());
    end
  endtask

  task automatic test_backpressure();
    int fires;
    fires = 0;
    rst = 1'b1;
    advance();
    rst = 1'b0; inst_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bp_stall%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (imem_re) fires++;
      advance();
    end
    #1;
    checks++;
    if (fires != 2 || imem_addr !== 32'd2 || imem_re !== 1'b0) begin
      failures++;
      $display("FAIL bp_fetches got fires=%0d addr=%0d re=%b exp fires=2 addr=2 re=0", fires, imem_addr, imem_re);
    end
    inst_ready = 1'b1;
    got_pc.delete();
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bp_release%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (inst_valid && inst_ready) got_pc.push_back(inst_pc);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got_pc.size() || got_pc[k] !== 32'(k)) begin
        failures++;
        $display("FAIL bp_order idx=%0d got=%0d exp=%0d", k, (k < got_pc.size()) ? got_pc[k] : 32'hx, k);
      end
    end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd5;
    advance();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL redir_fill%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      advance();
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd21;
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd5 || imem_re !== 1'b0) begin
      failures++;
      $display("FAIL redir_pre got valid=%b pc=%0d re=%b exp 1 5 0", inst_valid, inst_pc, imem_re);
    end
    advance();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'd21) begin
      failures++;
      $display("FAIL redir_flush got valid=%b addr=%0d exp valid=0 addr=21", inst_valid, imem_addr);
    end
    got_pc.delete(); got_inst.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL redir_run%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (inst_valid && inst_ready) begin got_pc.push_back(inst_pc); got_inst.push_back(inst); end
      advance();
    end
    checks++;
    if (got_pc.size() == 0 || got_pc[0] !== 32'd21 || got_inst[0] !== 32'h002105B3) begin
      failures++;
      $display("FAIL redir_target got pc=%0d inst=%h exp pc=21 inst=002105b3",
               (got_pc.size() != 0) ? got_pc[0] : 32'hx, (got_inst.size() != 0) ? got_inst[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd255;
    advance();
    redirect_valid = 1'b0;
    got_pc.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_cycle%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (inst_valid && inst_ready) got_pc.push_back(inst_pc);
      advance();
    end
    checks++;
    if (got_pc.size() != 3 || got_pc[0] !== 32'd255 || got_pc[1] !== 32'd0 || got_pc[2] !== 32'd1) begin
      failures++;
      $display("FAIL wrap_seq got n=%0d first=%0d exp n=3 pcs 255,0,1", got_pc.size(), (got_pc.size() != 0) ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_stall();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd30;
    advance();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rst_fill%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      advance();
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd99;
    advance();
    rst = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rst_mid_stall got valid=%b halted=%b addr=%0d exp 0 0 %0d", inst_valid, halted, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) imem[$urandom_range(0, MEM_SIZE - 1)] = 32'd0;
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 149) == 0);
      enable         = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      #1;
      if (!rst) begin
        checks++;
        if (obs_vec !== exp_vec()) begin
          failures++;
          $display("FAIL rand_cycle%0d got=%h exp=%h", i, obs_vec, exp_vec());
        end
      end
      advance();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_pc = RESET_PC; m_halt = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) imem[i] = $urandom() | 32'h0000_0010;
    imem[0]  = 32'h00302083;
    imem[7]  = 32'd0;
    imem[21] = 32'h002105B3;
    test_reset();
    test_sequential();
    test_halt();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
